jt51_lfo_mod: RTL and testbench

- Low-frequency oscillator that produces the amplitude-modulation word `am[6:0]` consumed by the envelope generator's AM stage.
- Also produces the signed pitch-modulation word `pm[7:0]` consumed by the phase generator.
- Advances once per output sample (`clk_en && zero`).
- Depth scaling uses a serial shift-add multiplier, so outputs refresh a fixed number of `clk_en` cycles after each sample tick.

---
 rtl/jt51_lfo_pkg.sv | 29 ++
 rtl/jt51_lfo_mul.sv | 77 +++++++
 rtl/jt51_lfo_mod.sv | 233 +++++++++++++++++++++++
 tb/tb_jt51_lfo_mod.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jt51_lfo_pkg.sv
// Shared codes and constants for the jt51 LFO: waveform and FSM encodings,
// noise LFSR geometry and its default seed.
package jt51_lfo_pkg;

    typedef enum logic [1:0] {
        SAW    = 2'd0,
        SQUARE = 2'd1,
        TRI    = 2'd2,
        NOISE  = 2'd3
    } wave_e;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_e;

    localparam int LFSR_W     = 17;
    localparam int LFSR_TAP_A = 16;
    localparam int LFSR_TAP_B = 13;
    localparam int MUL_STEPS  = 8;

    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 17'h00001;

    // Fibonacci step for x^17 + x^14 + 1
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], s[LFSR_TAP_A] ^ s[LFSR_TAP_B]};
    endfunction

endpackage

// File: rtl/jt51_lfo_mul.sv
// Serial 8x7 shift-add multiplier, one partial product per step.
// With IS_SIGNED the 8-bit operand is two's complement and the result is signed.
module jt51_lfo_mul #(
    parameter bit IS_SIGNED = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    input  logic [7:0]  a,
    input  logic [6:0]  b,
    output logic [15:0] res
);

    logic [7:0]  a_r;
    logic [14:0] b_r;
    logic [14:0] p_r;
    logic        neg_r;
    logic [7:0]  a_mag_s;
    logic        a_neg_s;
    logic [14:0] p_nx_s;

    // split a signed operand into sign and magnitude; -128 maps to 8'h80
    always_comb begin
        if (IS_SIGNED && a[7]) begin
            a_neg_s = 1'b1;
            a_mag_s = 8'h00 - a;
        end else begin
            a_neg_s = 1'b0;
            a_mag_s = a;
        end
    end

    // partial product including the bit currently at the bottom of a_r
    always_comb begin
        if (a_r[0]) begin
            p_nx_s = p_r + b_r;
        end else begin
            p_nx_s = p_r;
        end
    end

    // operand shift registers and accumulator
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_r   <= 8'h00;
            b_r   <= 15'h0000;
            p_r   <= 15'h0000;
            neg_r <= 1'b0;
        end else if (load) begin
            a_r   <= a_mag_s;
            b_r   <= {8'h00, b};
            p_r   <= 15'h0000;
            neg_r <= a_neg_s;
        end else if (step) begin
            a_r   <= {1'b0, a_r[7:1]};
            b_r   <= {b_r[13:0], 1'b0};
            p_r   <= p_nx_s;
            neg_r <= neg_r;
        end else begin
            a_r   <= a_r;
            b_r   <= b_r;
            p_r   <= p_r;
            neg_r <= neg_r;
        end
    end

    // result is valid on the final step, before the accumulator register catches up
    always_comb begin
        if (neg_r) begin
            res = 16'h0000 - {1'b0, p_nx_s};
        end else begin
            res = {1'b0, p_nx_s};
        end
    end

endmodule

// File: rtl/jt51_lfo_mod.sv
// jt51 LFO: phase accumulator, waveform shaping and serial AM/PM depth scaling.
// Define JT51_LFO_NOISE_EN to build the LFSR noise source for waveform 3.
module jt51_lfo_mod
    import jt51_lfo_pkg::*;
#(
    parameter int                ACC_W = 20,
    parameter logic [LFSR_W-1:0] SEED  = DEFAULT_SEED
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_en,
    input  logic       zero,
    input  logic       lfo_rst,
    input  logic [7:0] lfrq,
    input  logic [1:0] w,
    input  logic [6:0] amd,
    input  logic [6:0] pmd,
    output logic [6:0] am,
    output logic [7:0] pm,
    output logic       upd
);

    logic             tick_s;
    logic [ACC_W-1:0] acc_r;
    logic [ACC_W-1:0] lfo_step_s;
    logic [ACC_W-1:0] acc_new_s;
    logic [7:0]       phase_old_s;
    logic [7:0]       phase_s;
    logic [7:0]       noise_wu_s;
    logic [7:0]       noise_ws_s;
    logic [7:0]       wu_s;
    logic [7:0]       ws_s;
    logic [6:0]       amd_s;
    logic [6:0]       pmd_s;

    state_e           state_r;
    state_e           state_nx_s;
    logic [2:0]       cnt_r;
    logic [2:0]       cnt_nx_s;
    logic             load_s;
    logic             mul_step_s;
    logic             fin_s;

    logic [15:0]      am_res_s;
    logic [15:0]      pm_res_s;
    logic [6:0]       am_r;
    logic [7:0]       pm_r;
    logic             upd_r;
    logic             unused_res_s;

    assign tick_s      = clk_en & zero;
    assign lfo_step_s  = ACC_W'({1'b1, lfrq[3:0]}) << lfrq[7:4];
    assign acc_new_s   = lfo_rst ? {ACC_W{1'b0}} : acc_r + lfo_step_s;
    assign phase_old_s = acc_r[ACC_W-1 -: 8];
    assign phase_s     = acc_new_s[ACC_W-1 -: 8];

    // phase accumulator; lfo_rst pins it to the origin on any enabled cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_r <= {ACC_W{1'b0}};
        end else if (tick_s || (clk_en && lfo_rst)) begin
            acc_r <= acc_new_s;
        end else begin
            acc_r <= acc_r;
        end
    end

`ifdef JT51_LFO_NOISE_EN
    logic [LFSR_W-1:0] lfsr_r;
    logic [7:0]        noise_r;
    logic [7:0]        noise_new_s;

    // noise takes the pre-advance LFSR byte only when the phase actually moves
    always_comb begin
        if (!lfo_rst && (phase_s != phase_old_s)) begin
            noise_new_s = lfsr_r[7:0];
        end else begin
            noise_new_s = noise_r;
        end
    end

    // LFSR advances once per tick; lfo_rst reloads the seed
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_r  <= SEED;
            noise_r <= 8'h00;
        end else if (clk_en && lfo_rst) begin
            lfsr_r  <= SEED;
            noise_r <= noise_r;
        end else if (tick_s) begin
            lfsr_r  <= lfsr_step(lfsr_r);
            noise_r <= noise_new_s;
        end else begin
            lfsr_r  <= lfsr_r;
            noise_r <= noise_r;
        end
    end

    assign noise_wu_s = noise_new_s;
    assign noise_ws_s = noise_new_s ^ 8'h80;
`else
    logic unused_seed_s;

    assign noise_wu_s    = 8'h00;
    assign noise_ws_s    = 8'h00;
    assign unused_seed_s = ^SEED;
`endif

    // unsigned and signed waveform samples from the post-tick phase
    always_comb begin
        wu_s = 8'h00;
        ws_s = 8'h00;
        case (w)
            SAW: begin
                wu_s = phase_s;
                ws_s = phase_s ^ 8'h80;
            end
            SQUARE: begin
                wu_s = phase_s[7] ? 8'hFF : 8'h00;
                ws_s = phase_s[7] ? 8'h7F : 8'h80;
            end
            TRI: begin
                wu_s = {phase_s[6:0] ^ {7{phase_s[7]}}, 1'b0};
                ws_s = {phase_s[6:0] ^ {7{phase_s[7]}}, 1'b0} ^ 8'h80;
            end
            NOISE: begin
                wu_s = noise_wu_s;
                ws_s = noise_ws_s;
            end
            default: begin
                wu_s = 8'h00;
                ws_s = 8'h00;
            end
        endcase
    end

    // zero depth while lfo_rst is held forces both products to zero
    assign amd_s = lfo_rst ? 7'h00 : amd;
    assign pmd_s = lfo_rst ? 7'h00 : pmd;

    // FSM state and iteration count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= 3'd0;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
        end
    end

    // next state: a tick always (re)starts the multiply
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        if (!clk_en) begin
            state_nx_s = state_r;
            cnt_nx_s   = cnt_r;
        end else if (tick_s) begin
            state_nx_s = MUL;
            cnt_nx_s   = 3'd0;
        end else if (state_r == MUL) begin
            if (cnt_r == 3'(MUL_STEPS - 1)) begin
                state_nx_s = IDLE;
                cnt_nx_s   = 3'd0;
            end else begin
                cnt_nx_s = cnt_r + 3'd1;
            end
        end else begin
            state_nx_s = IDLE;
            cnt_nx_s   = 3'd0;
        end
    end

    // FSM control outputs
    always_comb begin
        load_s     = tick_s;
        mul_step_s = 1'b0;
        fin_s      = 1'b0;
        if (clk_en && !tick_s && (state_r == MUL)) begin
            mul_step_s = 1'b1;
            fin_s      = (cnt_r == 3'(MUL_STEPS - 1));
        end else begin
            mul_step_s = 1'b0;
            fin_s      = 1'b0;
        end
    end

    jt51_lfo_mul #(.IS_SIGNED(1'b0)) u_mul_am (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load_s),
        .step  (mul_step_s),
        .a     (wu_s),
        .b     (amd_s),
        .res   (am_res_s)
    );

    jt51_lfo_mul #(.IS_SIGNED(1'b1)) u_mul_pm (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load_s),
        .step  (mul_step_s),
        .a     (ws_s),
        .b     (pmd_s),
        .res   (pm_res_s)
    );

    // am = product >> 8, pm = signed product >>> 7 (floor)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            am_r  <= 7'h00;
            pm_r  <= 8'h00;
            upd_r <= 1'b0;
        end else begin
            upd_r <= fin_s;
            if (fin_s) begin
                am_r <= am_res_s[14:8];
                pm_r <= pm_res_s[14:7];
            end else begin
                am_r <= am_r;
                pm_r <= pm_r;
            end
        end
    end

    assign unused_res_s = ^{am_res_s[15], am_res_s[7:0], pm_res_s[15], pm_res_s[6:0]};

    assign am  = am_r;
    assign pm  = pm_r;
    assign upd = upd_r;

endmodule

// File: tb/tb_jt51_lfo_mod.sv
// Self-checking bench for jt51_lfo_mod: directed scenarios plus random traffic,
// compared every cycle against an arithmetic model of the oscillator.
`timescale 1ns/1ps
module tb_jt51_lfo_mod;

    logic       clk = 1'b0;
    logic       rst_n, clk_en, zero, lfo_rst;
    logic [7:0] lfrq;
    logic [1:0] w;
    logic [6:0] amd, pmd;
    logic [6:0] am;
    logic [7:0] pm;
    logic       upd;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    int          m_acc, m_noise, m_cnt, m_pam, m_ppm, m_am, m_pm;
    logic [16:0] m_lfsr;
    bit          m_pend, m_upd;

    jt51_lfo_mod dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clk_en  (clk_en),
        .zero    (zero),
        .lfo_rst (lfo_rst),
        .lfrq    (lfrq),
        .w       (w),
        .amd     (amd),
        .pmd     (pmd),
        .am      (am),
        .pm      (pm),
        .upd     (upd)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // waveform value from phase p (0..255) and the scaled outputs, in plain arithmetic
    function automatic void model_out(input int wv, input int p, input int nz,
                                      input int ad, input int pd,
                                      output int ea, output int ep);
        int wu, ws, prod;
        case (wv)
            0: begin wu = p; ws = p - 128; end
            1: begin wu = (p >= 128) ? 255 : 0; ws = (p >= 128) ? 127 : -128; end
            2: begin wu = (p < 128) ? 2 * p : 2 * (255 - p); ws = wu - 128; end
            default: begin
`ifdef JT51_LFO_NOISE_EN
                wu = nz; ws = nz - 128;
`else
                wu = 0; ws = 0;
`endif
            end
        endcase
        ea   = (wu * ad) / 256;
        prod = ws * pd;
        if (prod >= 0) ep = prod / 128;
        else           ep = -((-prod + 127) / 128);
    endfunction

    task automatic model_edge();
        int old_p, p, ea, ep;
        m_upd = 1'b0;
        if (!rst_n) begin
            m_acc = 0; m_lfsr = 17'h00001; m_noise = 0;
            m_pend = 1'b0; m_cnt = 0; m_am = 0; m_pm = 0;
        end else if (clk_en) begin
            if (lfo_rst) begin
                m_acc = 0; m_lfsr = 17'h00001;
            end
            if (zero) begin
                if (!lfo_rst) begin
                    old_p = m_acc / 4096;
                    m_acc = (m_acc + ((16 + int'(lfrq[3:0])) << lfrq[7:4])) % (1 << 20);
                    p     = m_acc / 4096;
                    if (p != old_p) m_noise = int'(m_lfsr[7:0]);
                    m_lfsr = {m_lfsr[15:0], m_lfsr[16] ^ m_lfsr[13]};
                end else begin
                    p = 0;
                end
                model_out(int'(w), p, m_noise, lfo_rst ? 0 : int'(amd),
                          lfo_rst ? 0 : int'(pmd), ea, ep);
                m_pam = ea; m_ppm = ep; m_pend = 1'b1; m_cnt = 8;
            end else if (m_pend) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_am = m_pam; m_pm = m_ppm; m_upd = 1'b1; m_pend = 1'b0;
                end
            end
        end
    endtask

    // every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("am", {25'h0, am}, m_am);
            check("pm", {24'h0, pm}, m_pm & 255);
            check("upd", {31'h0, upd}, int'(m_upd));
        end
    end

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic tick();
        zero = 1'b1;
        cyc();
        zero = 1'b0;
    endtask

    initial begin
        int ea, ep;
        rst_n = 1'b0; clk_en = 1'b1; zero = 1'b0; lfo_rst = 1'b0;
        lfrq = 8'h00; w = 2'd0; amd = 7'd0; pmd = 7'd0;

        model_out(2, 128, 0, 127, 127, ea, ep);
        check("pin_tri128_am", 32'(ea), 126);
        model_out(2, 192, 0, 127, 127, ea, ep);
        check("pin_tri192_am", 32'(ea), 62);
        model_out(1, 128, 0, 64, 127, ea, ep);
        check("pin_sq128_pm", 32'(ep), 126);
        model_out(0, 0, 0, 127, 127, ea, ep);
        check("pin_saw0_pm", 32'(ep), -127);

        cyc();
        chk_en = 1'b1;
        run(2);
        rst_n = 1'b1;
        check("rst_am", {25'h0, am}, 0);
        check("rst_pm", {24'h0, pm}, 0);
        check("rst_upd", {31'h0, upd}, 0);

        // saw
        w = 2'd0; lfrq = 8'hF0; amd = 7'd127; pmd = 7'd127;
        run(2);
        tick(); run(7);
        check("saw1_upd_early", {31'h0, upd}, 0);
        run(1);
        check("saw1_upd", {31'h0, upd}, 1);
        check("saw1_am", {25'h0, am}, 63);
        check("saw1_pm", {24'h0, pm}, 0);
        run(1);
        check("saw1_upd_pulse", {31'h0, upd}, 0);
        run(22);
        tick(); run(8);
        check("saw2_am", {25'h0, am}, 0);
        check("saw2_pm", {24'h0, pm}, 8'h81);
        run(4);

        // square
        w = 2'd1; amd = 7'd64;
        tick(); run(8);
        check("sq1_am", {25'h0, am}, 63);
        check("sq1_pm", {24'h0, pm}, 8'h7E);
        tick(); run(8);
        check("sq2_am", {25'h0, am}, 0);
        check("sq2_pm", {24'h0, pm}, 8'h81);

        // triangle, phase steps by 64
        w = 2'd2; lfrq = 8'hE0; amd = 7'd127;
        tick(); run(8);
        check("tri64_am", {25'h0, am}, 63);
        check("tri64_pm", {24'h0, pm}, 0);
        tick(); run(8);
        tick(); run(8);
        check("tri192_am", {25'h0, am}, 62);
        check("tri192_pm", {24'h0, pm}, 8'hFE);

        // stall mid-multiply
        w = 2'd0; lfrq = 8'hF3;
        tick(); run(3);
        clk_en = 1'b0; run(5); clk_en = 1'b1;
        run(4);
        check("stall_upd_early", {31'h0, upd}, 0);
        run(1);
        check("stall_upd", {31'h0, upd}, 1);

        // abort by a second tick; operand changes after the tick must not matter
        tick(); run(4);
        tick(); amd = 7'd5; pmd = 7'd9; w = 2'd1;
        run(3);
        check("abort_no_upd", {31'h0, upd}, 0);
        run(4);
        check("abort_upd_early", {31'h0, upd}, 0);
        run(1);
        check("abort_upd", {31'h0, upd}, 1);

        // lfo_rst held over four ticks
        lfo_rst = 1'b1; w = 2'd0; amd = 7'd127; pmd = 7'd127;
        repeat (4) begin
            tick(); run(8);
            check("lforst_am", {25'h0, am}, 0);
            check("lforst_pm", {24'h0, pm}, 0);
            run(2);
        end
        lfo_rst = 1'b0; lfrq = 8'hA5;
        run(1);
        tick(); run(8);
        check("release_am", {25'h0, am}, 2);
        check("release_pm", {24'h0, pm}, 8'h85);

`ifndef JT51_LFO_NOISE_EN
        w = 2'd3;
        tick(); run(8);
        check("noise_off_am", {25'h0, am}, 0);
        check("noise_off_pm", {24'h0, pm}, 0);
`endif

        // random traffic
        for (int i = 0; i < 5000; i++) begin
            rst_n   = ($urandom_range(1499) != 0);
            clk_en  = ($urandom_range(9) != 0);
            zero    = ($urandom_range(11) == 0);
            lfo_rst = ($urandom_range(63) == 0);
            if ($urandom_range(15) == 0) lfrq = {4'($urandom_range(15, 6)), 4'($urandom)};
            if ($urandom_range(15) == 0) w    = 2'($urandom);
            if ($urandom_range(15) == 0) amd  = 7'($urandom);
            if ($urandom_range(15) == 0) pmd  = 7'($urandom);
            cyc();
        end
        rst_n = 1'b1; clk_en = 1'b1; zero = 1'b0; lfo_rst = 1'b0;
        run(12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
